// File: rtl/adder_pipe_if.sv
// adder_pipe_if: operand/result stream bundle for adder_pipe.
// slave: in_valid/in1/in2/cin/sub/out_ready in; in_ready/out_valid/sum/cout/ovf out.
interface adder_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport slave (
    input  in_valid, in1, in2, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, in1, in2, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined add/sub, one CW-bit carry chunk per stage.
// Ports: clk, rst (sync, active-high), bus (adder_pipe_if.slave).
module adder_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic        clk,
  input  logic        rst,
  adder_pipe_if.slave bus
);
  localparam int CW = WIDTH / STAGES;

  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] v;

  assign rdy[STAGES]  = bus.out_ready;
  assign bus.in_ready = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : st
    localparam int LO = k * CW;
    localparam int HI = LO + CW;
    // operand bits still to be added when a beat reaches this stage
    localparam int PW = WIDTH - LO;

    logic [PW-1:0] pa;
    logic [PW-1:0] pb;
    logic          pc;
    logic          pv;
    logic [HI-1:0] sn;
    logic [CW:0]   add;

    logic          vq;
    logic          cq;
    logic [HI-1:0] sq;

    assign add = {1'b0, pa[CW-1:0]}
               + {1'b0, pb[CW-1:0]}
               + (CW+1)'(pc);

    if (k == 0) begin : src
      assign pa = bus.in1;
      assign pb = bus.sub ? ~bus.in2 : bus.in2;
      assign pc = bus.cin ^ bus.sub;
      assign pv = bus.in_valid;
      assign sn = add[CW-1:0];
    end else begin : src
      assign pa = st[k-1].pend.aq;
      assign pb = st[k-1].pend.bq;
      assign pc = st[k-1].cq;
      assign pv = st[k-1].vq;
      assign sn = {add[CW-1:0], st[k-1].sq};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vq <= 1'b0;
        cq <= 1'b0;
        sq <= '0;
      end else if (rdy[k]) begin
        vq <= pv;
        if (pv) begin
          cq <= add[CW];
          sq <= sn;
        end
      end
    end

    if (k < STAGES - 1) begin : pend
      logic [PW-CW-1:0] aq;
      logic [PW-CW-1:0] bq;

      always_ff @(posedge clk) begin
        if (rst) begin
          aq <= '0;
          bq <= '0;
        end else if (rdy[k] && pv) begin
          aq <= pa[PW-1:CW];
          bq <= pb[PW-1:CW];
        end
      end
    end else begin : fin
      logic oq;

      // same-sign operands giving an opposite-sign result
      always_ff @(posedge clk) begin
        if (rst) begin
          oq <= 1'b0;
        end else if (rdy[k] && pv) begin
          oq <= (pa[CW-1] == pb[CW-1])
              & (add[CW-1] ^ pa[CW-1]);
        end
      end
    end

    assign v[k]   = vq;
    assign rdy[k] = !vq | rdy[k+1];
  end

  assign bus.out_valid = v[STAGES-1];
  assign bus.sum       = st[STAGES-1].sq;
  assign bus.cout      = st[STAGES-1].cq;
  assign bus.ovf       = st[STAGES-1].fin.oq;
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: scoreboard bench for adder_pipe.
// Drives bus as master; results matched in acceptance order.
module tb_adder_pipe;
  localparam int W = 64;
  localparam int S = 4;

  typedef logic [W+1:0] res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_pipe_if #(.WIDTH(W)) bus();

  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  res_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  function automatic res_t model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         ci,
    input logic         sb
  );
    logic [W:0]   t;
    logic [W+1:0] sa;
    logic [W+1:0] sbb;
    logic [W+1:0] r;
    logic         o;
    t   = {1'b0, a} + {1'b0, (sb ? ~b : b)} + (W+1)'(ci ^ sb);
    sa  = {{2{a[W-1]}}, a};
    sbb = {{2{b[W-1]}}, b};
    r   = sb ? sa - sbb - (W+2)'(ci) : sa + sbb + (W+2)'(ci);
    o   = !((r[W+1:W-1] == 3'b000) || (r[W+1:W-1] == 3'b111));
    return {t[W], o, t[W-1:0]};
  endfunction

  task automatic drive(
    input logic         vld,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         ci,
    input logic         sb
  );
    bus.in_valid = vld;
    bus.in1      = a;
    bus.in2      = b;
    bus.cin      = ci;
    bus.sub      = sb;
  endtask

  // one clock: sample handshakes before the edge, push accepted beats
  task automatic cycle(
    output logic acc,
    output logic ofire,
    output res_t ob
  );
    #1;
    acc   = bus.in_valid & bus.in_ready;
    ofire = bus.out_valid & bus.out_ready;
    ob    = {bus.cout, bus.ovf, bus.sum};
    if (acc) sbq.push_back(model(bus.in1, bus.in2, bus.cin, bus.sub));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_one(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    input  logic         sb,
    output res_t         got,
    output int           lat
  );
    logic acc, of;
    res_t ob;
    sbq.delete();
    got = 'x;
    lat = -1;
    bus.out_ready = 1'b1;
    drive(1'b1, a, b, ci, sb);
    for (int i = 0; i < 10; i++) begin
      cycle(acc, of, ob);
      if (acc) break;
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      cycle(acc, of, ob);
      if (of) begin
        lat = i;
        got = ob;
        break;
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    n_cmp++;
    if ({bus.cout, bus.ovf, bus.sum} !== '0) begin
      n_bad++;
      $display("FAIL reset_data got=%h exp=0", {bus.cout, bus.ovf, bus.sum});
    end
  endtask

  task automatic test_carry();
    res_t got;
    int   lat;
    run_one({W{1'b1}}, '0, 1'b1, 1'b0, got, lat);
    n_cmp++;
    if (lat != S) begin
      n_bad++;
      $display("FAIL carry_latency got=%0d exp=%0d", lat, S);
    end
    n_cmp++;
    if (got !== {1'b1, 1'b0, 64'h0}) begin
      n_bad++;
      $display("FAIL carry_result got=%h exp=%h", got, {1'b1, 1'b0, 64'h0});
    end
  endtask

  task automatic test_sub();
    res_t got;
    int   lat;
    run_one(64'd5, 64'd7, 1'b0, 1'b1, got, lat);
    n_cmp++;
    if (got !== {2'b00, 64'hFFFF_FFFF_FFFF_FFFE}) begin
      n_bad++;
      $display("FAIL sub_cin0 got=%h lat=%0d", got, lat);
    end
    run_one(64'd5, 64'd7, 1'b1, 1'b1, got, lat);
    n_cmp++;
    if (got !== {2'b00, 64'hFFFF_FFFF_FFFF_FFFD}) begin
      n_bad++;
      $display("FAIL sub_cin1 got=%h lat=%0d", got, lat);
    end
  endtask

  task automatic test_ovf();
    res_t got;
    int   lat;
    run_one(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, got, lat);
    n_cmp++;
    if (got !== {2'b01, 64'h8000_0000_0000_0000}) begin
      n_bad++;
      $display("FAIL ovf_add got=%h lat=%0d", got, lat);
    end
    run_one(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, got, lat);
    n_cmp++;
    if (got !== {2'b11, 64'h7FFF_FFFF_FFFF_FFFF}) begin
      n_bad++;
      $display("FAIL ovf_sub got=%h lat=%0d", got, lat);
    end
  endtask

  task automatic test_stream();
    logic acc, of;
    res_t ob, ex;
    int   i = 1;
    int   c;
    int   first_acc = -1;
    int   first_out = -1;
    int   last_out  = -1;
    int   n_out     = 0;
    sbq.delete();
    bus.out_ready = 1'b1;
    for (int t = 0; t < 40 && n_out < 8; t++) begin
      if (i <= 8) drive(1'b1, 64'(i), 64'(i) << 32, 1'b0, 1'b0);
      else drive(1'b0, '0, '0, 1'b0, 1'b0);
      c = cyc;
      cycle(acc, of, ob);
      if (i <= 8) begin
        n_cmp++;
        if (!acc) begin
          n_bad++;
          $display("FAIL stream_in_ready beat=%0d got=0 exp=1", i);
        end else begin
          if (first_acc < 0) first_acc = c;
          i++;
        end
      end
      if (of) begin
        if (first_out < 0) first_out = c;
        last_out = c;
        n_out++;
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL stream_sb got=%h exp=none", ob);
        end else begin
          ex = sbq.pop_front();
          if (ob !== ex) begin
            n_bad++;
            $display("FAIL stream_sb got=%h exp=%h", ob, ex);
          end
        end
        n_cmp++;
        if (ob[W-1:0] !== (64'(n_out) + (64'(n_out) << 32))) begin
          n_bad++;
          $display("FAIL stream_order n=%0d got=%h", n_out, ob[W-1:0]);
        end
      end
    end
    n_cmp++;
    if (n_out != 8) begin
      n_bad++;
      $display("FAIL stream_count got=%0d exp=8", n_out);
    end
    n_cmp++;
    if (first_out - first_acc != S) begin
      n_bad++;
      $display("FAIL stream_first got=%0d exp=%0d", first_out - first_acc, S);
    end
    n_cmp++;
    if (last_out - first_out != 7) begin
      n_bad++;
      $display("FAIL stream_span got=%0d exp=7", last_out - first_out);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ba[8];
    logic [W-1:0] bb[8];
    logic [7:0]   bs;
    logic         acc, of, have;
    res_t         ob, ex, held;
    int           nacc = 0;
    int           n_out = 0;
    int           c;
    int           first_out = -1;
    int           last_out  = -1;
    for (int i = 0; i < 8; i++) begin
      ba[i] = {$urandom(), $urandom()};
      bb[i] = {$urandom(), $urandom()};
    end
    bs   = 8'(($urandom()));
    have = 1'b0;
    held = '0;
    sbq.delete();
    bus.out_ready = 1'b0;
    for (int t = 0; t < 8; t++) begin
      drive(1'b1, ba[nacc], bb[nacc], bs[nacc], bs[7-nacc]);
      cycle(acc, of, ob);
      if (acc) nacc++;
      if (bus.out_valid) begin
        if (!have) begin
          held = {bus.cout, bus.ovf, bus.sum};
          have = 1'b1;
        end else begin
          n_cmp++;
          if ({bus.cout, bus.ovf, bus.sum} !== held) begin
            n_bad++;
            $display("FAIL bp_stable got=%h exp=%h",
                     {bus.cout, bus.ovf, bus.sum}, held);
          end
        end
      end
    end
    n_cmp++;
    if (nacc != S) begin
      n_bad++;
      $display("FAIL bp_accepts got=%0d exp=%0d", nacc, S);
    end
    bus.out_ready = 1'b1;
    for (int t = 0; t < 20 && n_out < 8; t++) begin
      if (nacc < 8) drive(1'b1, ba[nacc], bb[nacc], bs[nacc], bs[7-nacc]);
      else drive(1'b0, '0, '0, 1'b0, 1'b0);
      c = cyc;
      cycle(acc, of, ob);
      if (t == 0) begin
        n_cmp++;
        if (!(acc && of)) begin
          n_bad++;
          $display("FAIL bp_release acc=%b out=%b exp=11", acc, of);
        end
      end
      if (acc) nacc++;
      if (of) begin
        if (first_out < 0) first_out = c;
        last_out = c;
        n_out++;
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL bp_sb got=%h exp=none", ob);
        end else begin
          ex = sbq.pop_front();
          if (ob !== ex) begin
            n_bad++;
            $display("FAIL bp_sb got=%h exp=%h", ob, ex);
          end
        end
      end
    end
    n_cmp++;
    if (n_out != 8 || last_out - first_out != 7) begin
      n_bad++;
      $display("FAIL bp_drain got=%0d span=%0d exp=8 span=7",
               n_out, last_out - first_out);
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL bp_leftover got=%0d exp=0", sbq.size());
    end
  endtask

  task automatic test_reset_mid();
    logic acc, of;
    res_t ob;
    int   nacc = 0;
    sbq.delete();
    bus.out_ready = 1'b1;
    for (int t = 0; t < 10 && nacc < 3; t++) begin
      drive(1'b1, 64'(t + 100), 64'(t), 1'b0, 1'b0);
      cycle(acc, of, ob);
      if (acc) nacc++;
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    cycle(acc, of, ob);
    rst = 1'b0;
    sbq.delete();
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_in_ready got=%b exp=1", bus.in_ready);
    end
    for (int t = 0; t < 10; t++) begin
      cycle(acc, of, ob);
      n_cmp++;
      if ({bus.out_valid, ob} !== '0) begin
        n_bad++;
        $display("FAIL rstmid_idle t=%0d got=%b/%h exp=0/0",
                 t, bus.out_valid, ob);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_carry();
    test_sub();
    test_ovf();
    test_stream();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
Parametrised, pipelined add/subtract unit for WIDTH-bit operands with a carry-in. It is the successor to the combinational ripple adder family. The carry chain is split into STAGES equal chunks, one chunk per register stage, so wide adds close timing at high clock rates. It adds a subtract mode, a signed-overflow flag and valid/ready handshakes with full backpressure, so it can drop into streaming datapaths.

Parameters:
WIDTH, 64, operand and sum width in bits; must be divisible by STAGES.
STAGES, 4, number of pipeline register stages; 1..WIDTH. Chunk width CW = WIDTH/STAGES.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept a beat this cycle
in1  input  WIDTH  operand A
in2  input  WIDTH  operand B
cin  input  1  carry-in (borrow-in when sub=1, see Behaviour)
sub  input  1  0 = add, 1 = subtract
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry-out of MSB (sub: 1 = no borrow)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset: synchronous and active-high. On a clk edge with rst=1, all stage valid bits are cleared, so out_valid=0. sum, cout and ovf are cleared to 0. Any in-flight beats are discarded. in_ready=1 in the cycle after reset.
- Operand conditioning at accept: B = sub ? ~in2 : in2, c0 = cin ^ sub.
  - sub=0: computes in1+in2+cin.
  - sub=1, cin=0: computes in1-in2.
  - sub=1, cin=1: computes in1-in2-1.
- Result arithmetic: {cout,sum} = in1 + B + c0, modulo 2^(WIDTH+1). ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Pipeline structure: stage k (0..STAGES-1) holds a valid bit v[k], the chunk-k sum, all lower sum chunks, the not-yet-added upper chunks of A and B, and the carry out of chunk k. For the final stage it holds ovf instead of the pending chunks.
- Stage 0 adds chunk 0 of the accepted inputs plus c0. Stage k adds chunk k of its predecessor's pending operands plus the predecessor's registered carry.
- Exactly one CW-bit ripple add is performed per stage. No carry path spans a register.
- Handshake, stage-k ready: rdy[STAGES-1] = !v[STAGES-1] | out_ready; rdy[k] = !v[k] | rdy[k+1]; in_ready = rdy[0].
  - in_ready is combinationally dependent on out_ready. This path is accepted.
  - Stage k loads from its predecessor when rdy[k]=1. A beat moves forward only when its target can accept. Bubbles collapse.
- Transfers: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Output mapping: out_valid = v[STAGES-1]. sum, cout and ovf come directly from the last-stage registers.
- Output stability: while out_valid=1 and out_ready=0, sum, cout and ovf hold stable.
- Latency: a beat accepted at edge N gives out_valid=1 after edge N+STAGES-1. That is STAGES cycles of latency with no backpressure. STAGES=1 degenerates to one registered full-width add.
- Throughput: 1 beat/cycle when out_ready is held at 1.
- Ordering: results leave in acceptance order. There is no loss and no duplication.
- Full pipeline: when all STAGES valid bits are set and out_ready=0, in_ready=0.
- Simultaneous events: if out_ready=1 in the same cycle the pipe is full, in_ready=1 and a new beat is accepted while the oldest leaves.
- Input qualification: in_valid is sampled only with in_ready. Operands and sub are captured at accept, so later changes do not affect in-flight beats.
- Wrap-around: sum wraps modulo 2^WIDTH, and the carry goes to cout.
- Reset mid-operation: flushes all beats. No out_valid pulse may occur for a beat accepted before reset.

Test Plan:
1. Carry through all chunks. WIDTH=64, STAGES=4, idle pipe. Apply in1=0xFFFF_FFFF_FFFF_FFFF, in2=0, cin=1, sub=0. Required: out_valid exactly 4 cycles after accept, sum=0, cout=1, ovf=0.
2. Subtract with borrow. Apply in1=5, in2=7, cin=0, sub=1. Required: sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Repeat with cin=1: sum=0xFFFF_FFFF_FFFF_FFFD.
3. Signed overflow. Apply in1=0x7FFF_FFFF_FFFF_FFFF, in2=1, add. Required: sum=0x8000_0000_0000_0000, ovf=1, cout=0. Then 0x8000_0000_0000_0000 - 1: sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
4. Streaming. Hold out_ready=1 and feed 8 back-to-back beats (in1=i, in2=i<<32, i=1..8). Required: in_ready stays 1. Outputs arrive on 8 consecutive cycles starting 4 cycles after the first accept, sum=i+(i<<32), in order.
5. Backpressure. Hold out_ready=0 while in_valid=1 with distinct beats. Required:
   - in_ready drops after exactly 4 accepts; sum is stable while stalled.
   - On release with out_ready=1, one beat drains per cycle and the 5th beat is accepted the same cycle as the first drain.
   - Every beat appears once, in order, against a scoreboard.
6. Reset mid-flight. Accept 3 beats, assert rst for 1 cycle, then idle. Required: out_valid=0 with sum/cout/ovf=0 for 10 cycles, and in_ready=1 in the cycle after reset.
